ppi_bus_master: RTL and testbench
=================================

PPI_BUS_MASTER -- requirements
Module: ppi_bus_master

Interface
REQ-001 SHALL provide parameter SETUP_CYC, default 1, cycles of address/strobe setup before Cs_n falls (4-bit; 0 treated as 1).
REQ-002 SHALL provide parameter STROBE_CYC, default 2, cycles Cs_n is held low (4-bit; 0 treated as 1).
REQ-003 SHALL provide parameter HOLD_CYC, default 1, cycles Wr_n/Rd_n, A and D are held after Cs_n rises (4-bit; 0 treated as 1).
REQ-004 Ports (clock and reset first):
  Clk  in  1  single clock; all state changes on rising edge.
  Reset_n  in  1  asynchronous, active-low reset.
  Req  in  1  transfer request; sampled only in IDLE.
  We  in  1  1 = write, 0 = read; sampled with Req.
  Addr  in  2  port select (00 A, 01 B, 10 C, 11 control); sampled with Req.
  Wdata  in  8  write data; sampled with Req.
  Ack  out  1  one-cycle completion pulse.
  Busy  out  1  high whenever state is not IDLE.
  Rdata  out  8  last captured read data.
  A  out  2  PPI address.
  Cs_n  out  1  PPI chip select, active low.
  Wr_n  out  1  PPI write strobe, active low.
  Rd_n  out  1  PPI read strobe, active low.
  D_out  out  8  PPI data bus drive value.
  D_oe  out  1  1 = drive PPI data bus with D_out.
  D_in  in  8  PPI data bus input.
REQ-005 All outputs SHALL be registered.

Function
REQ-006 States SHALL be IDLE, SETUP, STROBE, HOLD; one 4-bit down-counter times each phase.
REQ-007 IDLE with Req=1 at edge k SHALL latch We/Addr/Wdata and enter SETUP; Req=0 stays IDLE; Req outside IDLE SHALL be ignored (no queueing).
REQ-008 SETUP: A=Addr, Cs_n=1; write: Wr_n=0, D_oe=1, D_out=Wdata; read: Rd_n=0, D_oe=0; lasts SETUP_CYC cycles.
REQ-009 STROBE: Cs_n=0, other signals unchanged; lasts STROBE_CYC cycles, so Cs_n falls with Wr_n/Rd_n, A and D already stable.
REQ-010 Read: Rdata SHALL load D_in on the edge leaving STROBE; otherwise Rdata holds.
REQ-011 HOLD: Cs_n=1, Wr_n/Rd_n, A, D_out, D_oe unchanged; lasts HOLD_CYC cycles.
REQ-012 Edge leaving HOLD SHALL set Wr_n=1, Rd_n=1, D_oe=0, state IDLE, and Ack=1 for exactly one cycle; A and D_out hold last value.
REQ-013 Latency: Req sampled at edge k SHALL give Ack high from edge k+SETUP_CYC+STROBE_CYC+HOLD_CYC (k+4 at defaults).
REQ-014 Req high in the Ack cycle SHALL be accepted (back-to-back), giving Cs_n high for at least SETUP_CYC+HOLD_CYC cycles between strobes.
REQ-015 Wr_n and Rd_n SHALL never be low simultaneously; D_oe SHALL never be 1 during a read.

Reset
REQ-016 Reset_n=0 SHALL immediately force IDLE, Cs_n=1, Wr_n=1, Rd_n=1, D_oe=0, A=00, D_out=00, Rdata=00, Ack=0, Busy=0, counter 0.
REQ-017 Reset mid-transfer SHALL abort with no Ack; the first Req after Reset_n rises SHALL be handled normally.

Configuration
REQ-018 With PPI_BM_READY_EN defined, SHALL add input Ready (1 bit) after D_in; STROBE SHALL exit only when its count has expired and Ready=1, extending Cs_n low one cycle per Ready=0 cycle.
REQ-019 Without PPI_BM_READY_EN, port Ready SHALL be absent and behaviour SHALL equal Ready tied 1.

Verification
REQ-020 Defaults, write Addr=11 Wdata=80 at edge 0 -> Wr_n low edges 1-4, Cs_n low edges 2-3 only, D_out=80 D_oe=1, Ack pulse at edge 4.
REQ-021 Defaults, read Addr=01, D_in=A5 -> Rd_n low, D_oe=0 throughout, Rdata=A5 at edge 3, Ack at edge 4.
REQ-022 Back-to-back writes (Req held high, Addr 00 then 10) -> two Cs_n pulses each 2 cycles, Cs_n high 2 cycles between, two Ack pulses 4 cycles apart.
REQ-023 Reset_n low during STROBE -> Cs_n/Wr_n high and D_oe=0 without a clock edge, no Ack, next request completes normally.
REQ-024 PPI_BM_READY_EN, Ready=0 for 3 cycles from STROBE entry -> Cs_n low 4 cycles, Ack at edge 6; without macro same stimulus -> Ack at edge 4.
REQ-025 Req pulsed while Busy=1 -> ignored, single Ack, no second transfer.

Source files
------------

// File: rtl/ppi_bus_master.sv
// Bus master for an 8255-style PPI: SETUP / STROBE / HOLD sequencing of A, Cs_n, Wr_n/Rd_n, D.
// Optional `PPI_BM_READY_EN adds a Ready input that stretches the Cs_n-low phase.
module ppi_bus_master #(
    parameter logic [3:0] SETUP_CYC  = 4'd1,
    parameter logic [3:0] STROBE_CYC = 4'd2,
    parameter logic [3:0] HOLD_CYC   = 4'd1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Req,
    input  logic       We,
    input  logic [1:0] Addr,
    input  logic [7:0] Wdata,
    output logic       Ack,
    output logic       Busy,
    output logic [7:0] Rdata,
    output logic [1:0] A,
    output logic       Cs_n,
    output logic       Wr_n,
    output logic       Rd_n,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
`ifdef PPI_BM_READY_EN
    ,
    input  logic       Ready
`endif
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Counter reload values; a phase length of 0 behaves as 1.
    localparam logic [3:0] SETUP_LD  = (SETUP_CYC  == 4'd0) ? 4'd0 : SETUP_CYC  - 4'd1;
    localparam logic [3:0] STROBE_LD = (STROBE_CYC == 4'd0) ? 4'd0 : STROBE_CYC - 4'd1;
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC   == 4'd0) ? 4'd0 : HOLD_CYC   - 4'd1;

    logic ready;
`ifdef PPI_BM_READY_EN
    assign ready = Ready;
`else
    assign ready = 1'b1;
`endif

    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic       we_q, we_d;
    logic       cnt_zero, hold_done, start, strobe_exit;

    logic       ack_d, busy_d, cs_n_d, wr_n_d, rd_n_d, d_oe_d;
    logic [1:0] a_d;
    logic [7:0] d_out_d, rdata_d;

    assign cnt_zero    = (cnt == 4'd0);
    assign hold_done   = (state == HOLD) && cnt_zero;
    // The edge that ends HOLD also acts as an IDLE sampling edge, so a held
    // Req chains transfers with only the HOLD+SETUP gap between strobes.
    assign start       = Req && ((state == IDLE) || hold_done);
    assign strobe_exit = (state == STROBE) && cnt_zero && ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (Req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - 4'd1;
                end else if (ready) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - 4'd1;
                end else if (Req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Next values for the registered bus outputs.
    always_comb begin
        we_d    = we_q;
        a_d     = A;
        d_out_d = D_out;
        d_oe_d  = D_oe;
        wr_n_d  = Wr_n;
        rd_n_d  = Rd_n;
        cs_n_d  = Cs_n;
        rdata_d = Rdata;
        ack_d   = hold_done;
        busy_d  = (state_d != IDLE);
        if (start) begin
            we_d   = We;
            a_d    = Addr;
            wr_n_d = !We;
            rd_n_d = We;
            d_oe_d = We;
            cs_n_d = 1'b1;
            if (We)
                d_out_d = Wdata;
        end else if (hold_done) begin
            wr_n_d = 1'b1;
            rd_n_d = 1'b1;
            d_oe_d = 1'b0;
        end
        if ((state == SETUP) && cnt_zero)
            cs_n_d = 1'b0;
        if (strobe_exit) begin
            cs_n_d = 1'b1;
            if (!we_q)
                rdata_d = D_in;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            we_q  <= 1'b0;
            A     <= 2'b00;
            D_out <= 8'h00;
            D_oe  <= 1'b0;
            Wr_n  <= 1'b1;
            Rd_n  <= 1'b1;
            Cs_n  <= 1'b1;
            Rdata <= 8'h00;
            Ack   <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            we_q  <= we_d;
            A     <= a_d;
            D_out <= d_out_d;
            D_oe  <= d_oe_d;
            Wr_n  <= wr_n_d;
            Rd_n  <= rd_n_d;
            Cs_n  <= cs_n_d;
            Rdata <= rdata_d;
            Ack   <= ack_d;
            Busy  <= busy_d;
        end
    end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master: directed scenarios then random traffic
// against a transaction-level timing model (default phase lengths 1/2/1).
module tb_ppi_bus_master;

    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
`ifdef PPI_BM_READY_EN
    localparam bit HAS_RDY = 1'b1;
`else
    localparam bit HAS_RDY = 1'b0;
`endif

    logic       Clk = 1'b0, Reset_n = 1'b0, Req = 1'b0, We = 1'b0, Ready = 1'b1;
    logic [1:0] Addr = 2'b00;
    logic [7:0] Wdata = 8'h00, D_in = 8'h00;
    logic       Ack, Busy, Cs_n, Wr_n, Rd_n, D_oe;
    logic [1:0] A;
    logic [7:0] Rdata, D_out;

    int tests = 0, fails = 0;

    ppi_bus_master dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .We(We), .Addr(Addr), .Wdata(Wdata),
        .Ack(Ack), .Busy(Busy), .Rdata(Rdata), .A(A), .Cs_n(Cs_n), .Wr_n(Wr_n),
        .Rd_n(Rd_n), .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
`ifdef PPI_BM_READY_EN
        , .Ready(Ready)
`endif
    );

    always #5 Clk = ~Clk;

    // Transaction-level model: one active transfer described by its accept edge
    // and the edge at which its strobe ended.
    int         n = 0;
    bit         m_busy = 0, m_ended = 0, m_ack = 0, m_we = 0;
    int         m_acc = 0, m_send = 0;
    logic [1:0] m_a = 2'b00;
    logic [7:0] m_dout = 8'h00, m_rdata = 8'h00;

    // Observations of the DUT taken in directed windows.
    int t0 = 0, first_ack = -1, ack_cnt = 0, cs_low = 0;
    int ack_edges[$];

    task automatic model_reset();
        m_busy = 0; m_ended = 0; m_ack = 0;
        m_a = 2'b00; m_dout = 8'h00; m_rdata = 8'h00;
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = HAS_RDY ? Ready : 1'b1;
        m_ack = 0;
        if (m_busy) begin
            if (!m_ended && n >= m_acc + S + ST && rdy) begin
                m_ended = 1;
                m_send  = n;
                if (!m_we) m_rdata = D_in;
            end else if (m_ended && n == m_send + H) begin
                m_ack  = 1;
                m_busy = 0;
            end
        end
        if (!m_busy && Req) begin
            m_busy = 1; m_ended = 0; m_acc = n;
            m_we = We; m_a = Addr;
            if (We) m_dout = Wdata;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: got %0h want %0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack",   32'(Ack),   32'(m_ack));
        chk("busy",  32'(Busy),  32'(m_busy));
        chk("rdata", 32'(Rdata), 32'(m_rdata));
        chk("a",     32'(A),     32'(m_a));
        chk("d_out", 32'(D_out), 32'(m_dout));
        chk("cs_n",  32'(Cs_n),  32'(!(m_busy && n >= m_acc + S && !m_ended)));
        chk("wr_n",  32'(Wr_n),  32'(!(m_busy && m_we)));
        chk("rd_n",  32'(Rd_n),  32'(!(m_busy && !m_we)));
        chk("d_oe",  32'(D_oe),  32'(m_busy && m_we));
        chk("no_dual_strobe", 32'(Wr_n | Rd_n), 32'd1);
    endtask

    task automatic step();
        @(posedge Clk);
        n++;
        model_edge();
        #1;
        if (Ack) begin
            ack_cnt++;
            ack_edges.push_back(n);
            if (first_ack < 0) first_ack = n;
        end
        if (!Cs_n) cs_low++;
        check_all();
    endtask

    task automatic open_window();
        first_ack = -1; ack_cnt = 0; cs_low = 0;
        ack_edges.delete();
    endtask

    initial begin
        // Reset state, checked while Reset_n is held low.
        #12;
        model_reset();
        check_all();
        @(negedge Clk) Reset_n = 1'b1;
        step();

        // Write to control port: Cs_n low 2 cycles inside a 4-cycle Wr_n window.
        open_window();
        Req = 1; We = 1; Addr = 2'b11; Wdata = 8'h80;
        step(); t0 = n;
        Req = 0;
        repeat (5) step();
        chk("wr_latency", 32'(first_ack - t0), 32'd4);
        chk("wr_cs_low",  32'(cs_low), 32'd2);
        chk("wr_acks",    32'(ack_cnt), 32'd1);

        // Read from port B.
        open_window();
        Req = 1; We = 0; Addr = 2'b01; D_in = 8'hA5;
        step(); t0 = n;
        Req = 0;
        repeat (5) step();
        chk("rd_latency", 32'(first_ack - t0), 32'd4);
        chk("rd_data",    32'(Rdata), 32'hA5);

        // Back-to-back writes with Req held high.
        open_window();
        Req = 1; We = 1; Addr = 2'b00; Wdata = 8'h11;
        step();
        Addr = 2'b10; Wdata = 8'h22;
        repeat (4) step();
        Req = 0;
        repeat (6) step();
        chk("b2b_acks",   32'(ack_cnt), 32'd2);
        chk("b2b_cs_low", 32'(cs_low), 32'd4);
        if (ack_edges.size() == 2)
            chk("b2b_ack_gap", 32'(ack_edges[1] - ack_edges[0]), 32'd4);
        chk("b2b_last_a", 32'(A), 32'd2);

        // Req pulsed while busy is ignored.
        open_window();
        Req = 1; We = 1; Addr = 2'b01; Wdata = 8'h33;
        step();
        Req = 0; step();
        Req = 1; step();
        Req = 0;
        repeat (6) step();
        chk("busy_req_acks", 32'(ack_cnt), 32'd1);

        // Asynchronous reset during STROBE aborts without Ack.
        open_window();
        Req = 1; We = 1; Addr = 2'b10; Wdata = 8'h44;
        step();
        Req = 0; step();
        chk("pre_rst_cs_n", 32'(Cs_n), 32'd0);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge Clk) Reset_n = 1'b1;
        repeat (3) step();
        chk("rst_no_ack", 32'(ack_cnt), 32'd0);
        open_window();
        Req = 1; We = 0; Addr = 2'b11; D_in = 8'h5A;
        step(); t0 = n;
        Req = 0;
        repeat (5) step();
        chk("post_rst_latency", 32'(first_ack - t0), 32'd4);
        chk("post_rst_rdata",   32'(Rdata), 32'h5A);

        // Ready low for 3 cycles from STROBE entry.
        open_window();
        Req = 1; We = 1; Addr = 2'b00; Wdata = 8'h55; Ready = 1;
        step(); t0 = n;
        Req = 0; step();
        Ready = 0;
        repeat (3) step();
        Ready = 1;
        repeat (4) step();
        chk("ready_latency", 32'(first_ack - t0), HAS_RDY ? 32'd6 : 32'd4);
        chk("ready_cs_low",  32'(cs_low), HAS_RDY ? 32'd4 : 32'd2);

        // Random traffic against the model.
        repeat (400) begin
            Req   = ($urandom_range(0, 2) == 0);
            We    = 1'($urandom);
            Addr  = 2'($urandom);
            Wdata = 8'($urandom);
            D_in  = 8'($urandom);
            Ready = ($urandom_range(0, 3) != 0);
            step();
        end
        Req = 0; Ready = 1;
        repeat (12) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
